// File: rtl/multi_line_loader.sv
`default_nettype none
// ============================================================================
// Module  : multi_line_loader
// Brief   : Loads NUM_LINES image rows around a centre row into line buffers,
//           packing narrow input words into OCH_PACK-channel output words and
//           zero-filling rows that fall outside the image.
// Rev     : 1.0
// ============================================================================
module multi_line_loader #(
  parameter int IFM_DATA_NUM   = 4,
  parameter int WI             = 8,
  parameter int OCH_PACK       = 16,
  parameter int NUM_LINES      = 3,
  parameter int RD_LAT         = 1,
  parameter int MAX_IFM_DEPTH  = 16,
  parameter int MAX_LINE_DEPTH = 8,
  localparam int R_DATA_W      = WI * IFM_DATA_NUM,
  localparam int W_DATA_W      = WI * OCH_PACK
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [7:0]                ifm_w,
  input  logic [7:0]                ifm_h,
  input  logic [7:0]                ich,
  input  logic [7:0]                line_idx,
  input  logic                      ap_start,
  output logic                      ap_busy,
  output logic                      ap_done,
  output logic [MAX_IFM_DEPTH-1:0]  r_addr,
  input  logic [R_DATA_W-1:0]       r_data,
  output logic [MAX_LINE_DEPTH-1:0] w_addr,
  output logic [W_DATA_W-1:0]       w_data,
  output logic                      w_en,
  output logic [NUM_LINES-1:0]      w_sel
);

  localparam int P    = OCH_PACK / IFM_DATA_NUM;
  localparam int JW   = (P > 1) ? $clog2(P) : 1;
  localparam int KW   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int HALF = (NUM_LINES - 1) / 2;
  localparam logic [JW-1:0] J_LAST = JW'(P - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_LINES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, READ, DRAIN, ZERO, NEXT, DONE} state_t;

  state_t                    state_q, state_d;
  logic [7:0]                w_q, w_d, h_q, h_d, ich_q, ich_d, li_q, li_d;
  logic [KW-1:0]             k_q, k_d;
  logic [MAX_IFM_DEPTH-1:0]  base_q, base_d;
  logic [15:0]               rcnt_q, rcnt_d;
  logic [15:0]               wcnt_q, wcnt_d;
  logic [RD_LAT:0]           v_q, v_d;
  logic [JW-1:0]             j_q, j_d;
  logic [7:0]                rp_q, rp_d;
  logic [W_DATA_W-1:0]       pk_q, pk_d;
  logic [MAX_IFM_DEPTH-1:0]  r_addr_q, r_addr_d;
  logic [MAX_LINE_DEPTH-1:0] w_addr_q, w_addr_d;
  logic [W_DATA_W-1:0]       w_data_q, w_data_d;
  logic                      w_en_q, w_en_d;
  logic [NUM_LINES-1:0]      w_sel_q, w_sel_d;
  logic                      busy_q, busy_d, done_q, done_d;

  logic [7:0]  w_rpp;
  logic [8:0]  w_cg;
  logic [15:0] w_rd_total, w_zr_total;
  logic [8:0]  w_y;
  logic        w_y_ok, w_issue, w_pix_end, w_grp_end;

  assign w_rpp      = ich_q / 8'(IFM_DATA_NUM);
  assign w_cg       = ({1'b0, ich_q} + 9'(OCH_PACK - 1)) / 9'(OCH_PACK);
  assign w_rd_total = 16'(w_q) * 16'(w_rpp);
  assign w_zr_total = 16'(w_q) * 16'(w_cg);
  // 9-bit wrap makes rows above the top read as negative, i.e. padded
  assign w_y        = {1'b0, li_q} - 9'(HALF) + 9'(k_q);
  assign w_y_ok     = !w_y[8] && (w_y[7:0] < h_q);
  assign w_pix_end  = (rp_q == w_rpp - 8'd1);
  assign w_grp_end  = (j_q == J_LAST) || w_pix_end;

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    h_d      = h_q;
    ich_d    = ich_q;
    li_d     = li_q;
    k_d      = k_q;
    base_d   = base_q;
    rcnt_d   = rcnt_q;
    wcnt_d   = wcnt_q;
    j_d      = j_q;
    rp_d     = rp_q;
    pk_d     = pk_q;
    r_addr_d = r_addr_q;
    w_addr_d = w_addr_q;
    w_data_d = '0;
    w_en_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    w_issue  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ap_start) begin
          w_d     = ifm_w;
          h_d     = ifm_h;
          ich_d   = ich;
          li_d    = line_idx;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        rcnt_d = '0;
        wcnt_d = '0;
        j_d    = '0;
        rp_d   = '0;
        pk_d   = '0;
        base_d = MAX_IFM_DEPTH'(w_y[7:0]) * MAX_IFM_DEPTH'(w_rd_total);
        if (w_q == 8'd0 || ich_q == 8'd0) state_d = DONE;
        else if (w_y_ok)                  state_d = READ;
        else                              state_d = ZERO;
      end
      READ: begin
        w_issue  = 1'b1;
        r_addr_d = base_q + MAX_IFM_DEPTH'(rcnt_q);
        rcnt_d   = rcnt_q + 16'd1;
        if (rcnt_q == w_rd_total - 16'd1) state_d = DRAIN;
      end
      DRAIN: begin
        if (v_q == '0) state_d = NEXT;
      end
      ZERO: begin
        if (wcnt_q == w_zr_total) begin
          state_d = NEXT;
        end else begin
          w_en_d   = 1'b1;
          w_addr_d = MAX_LINE_DEPTH'(wcnt_q);
          wcnt_d   = wcnt_q + 16'd1;
        end
      end
      NEXT: begin
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = SETUP;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Return side: v_q[RD_LAT] marks r_data belonging to an issued address
    v_d = {v_q[RD_LAT-1:0], w_issue};
    if (v_q[RD_LAT]) begin
      pk_d = pk_q;
      pk_d[R_DATA_W*j_q +: R_DATA_W] = r_data;
      if (w_grp_end) begin
        w_en_d   = 1'b1;
        w_data_d = pk_d;
        w_addr_d = MAX_LINE_DEPTH'(wcnt_q);
        wcnt_d   = wcnt_q + 16'd1;
        pk_d     = '0;
        j_d      = '0;
      end else begin
        j_d = j_q + JW'(1);
      end
      rp_d = w_pix_end ? 8'd0 : rp_q + 8'd1;
    end

    w_sel_d = w_en_d ? (NUM_LINES'(1) << k_q) : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      w_q      <= '0;
      h_q      <= '0;
      ich_q    <= '0;
      li_q     <= '0;
      k_q      <= '0;
      base_q   <= '0;
      rcnt_q   <= '0;
      wcnt_q   <= '0;
      v_q      <= '0;
      j_q      <= '0;
      rp_q     <= '0;
      pk_q     <= '0;
      r_addr_q <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_en_q   <= 1'b0;
      w_sel_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      h_q      <= h_d;
      ich_q    <= ich_d;
      li_q     <= li_d;
      k_q      <= k_d;
      base_q   <= base_d;
      rcnt_q   <= rcnt_d;
      wcnt_q   <= wcnt_d;
      v_q      <= v_d;
      j_q      <= j_d;
      rp_q     <= rp_d;
      pk_q     <= pk_d;
      r_addr_q <= r_addr_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_en_q   <= w_en_d;
      w_sel_q  <= w_sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign r_addr  = r_addr_q;
  assign w_addr  = w_addr_q;
  assign w_data  = w_data_q;
  assign w_en    = w_en_q;
  assign w_sel   = w_sel_q;
  assign ap_busy = busy_q;
  assign ap_done = done_q;

endmodule
`default_nettype wire
